// File: rtl/axi4lite_dmem_slave.sv
// axi4lite_dmem_slave: AXI4-Lite slave bridging single transactions onto the data memory port.
// Define DMEM_RANGE_CHECK_EN to answer SLVERR for addresses outside the BASE_ADDR window.
module axi4lite_dmem_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          MEM_AW    = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [31:0]       s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic              mem_write,
    output logic [3:0]        mem_byte_en,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    typedef enum logic [2:0] {IDLE, WR_RESP, RD_ADDR, RD_CAP, RD_RESP} state_t;
    state_t state_q, state_d;
    logic aw_full_q, aw_full_d, w_full_q, w_full_d;
    logic aw_err_q, aw_err_d, ar_err_q, ar_err_d;
    logic [MEM_AW-3:0] awaddr_q, awaddr_d, araddr_q, araddr_d, mem_addr_q, mem_addr_d;
    logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0] wstrb_q, wstrb_d;
    logic bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
    logic idle, commit, aw_hs, w_hs, ar_hs, aw_bad, ar_bad, unused;
`ifdef DMEM_RANGE_CHECK_EN
    assign aw_bad = s_axi_awaddr[31:MEM_AW] != BASE_ADDR[31:MEM_AW];
    assign ar_bad = s_axi_araddr[31:MEM_AW] != BASE_ADDR[31:MEM_AW];
    assign unused = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], BASE_ADDR[MEM_AW-1:0]};
`else
    assign aw_bad = 1'b0;
    assign ar_bad = 1'b0;
    assign unused = ^{s_axi_awaddr[31:MEM_AW], s_axi_awaddr[1:0],
                      s_axi_araddr[31:MEM_AW], s_axi_araddr[1:0], BASE_ADDR};
`endif
    // Readies are forced low while reset is held so nothing handshakes during reset.
    assign idle          = (state_q == IDLE) & rst;
    assign s_axi_awready = idle & ~aw_full_q;
    assign s_axi_wready  = idle & ~w_full_q;
    assign s_axi_arready = idle & ~aw_full_q & ~w_full_q & ~s_axi_awvalid & ~s_axi_wvalid;
    assign aw_hs         = s_axi_awvalid & s_axi_awready;
    assign w_hs          = s_axi_wvalid & s_axi_wready;
    assign ar_hs         = s_axi_arvalid & s_axi_arready;
    assign commit        = idle & aw_full_q & w_full_q;
    assign mem_write     = commit & ~aw_err_q;
    assign mem_byte_en   = commit ? wstrb_q : 4'b0000;
    assign mem_wdata     = wdata_q;
    assign mem_addr      = {mem_addr_d, 2'b00};
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;

    always_comb begin
        state_d   = state_q;
        aw_full_d = aw_full_q | aw_hs;
        w_full_d  = w_full_q | w_hs;
        awaddr_d  = aw_hs ? s_axi_awaddr[MEM_AW-1:2] : awaddr_q;
        aw_err_d  = aw_hs ? aw_bad : aw_err_q;
        wdata_d   = w_hs ? s_axi_wdata : wdata_q;
        wstrb_d   = w_hs ? s_axi_wstrb : wstrb_q;
        araddr_d  = ar_hs ? s_axi_araddr[MEM_AW-1:2] : araddr_q;
        ar_err_d  = ar_hs ? ar_bad : ar_err_q;
        mem_addr_d = commit ? awaddr_q : (state_q == RD_ADDR) ? araddr_q : mem_addr_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: begin
                if (ar_hs) state_d = RD_ADDR;
                if (commit) begin
                    aw_full_d = 1'b0;
                    w_full_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    bresp_d   = aw_err_q ? 2'b10 : 2'b00;
                    state_d   = WR_RESP;
                end
            end
            WR_RESP: if (s_axi_bready) begin
                bvalid_d = 1'b0;
                state_d  = IDLE;
            end
            RD_ADDR: state_d = RD_CAP;
            RD_CAP: begin
                rdata_d  = ar_err_q ? 32'h0 : mem_rdata;
                rresp_d  = ar_err_q ? 2'b10 : 2'b00;
                rvalid_d = 1'b1;
                state_d  = RD_RESP;
            end
            RD_RESP: if (s_axi_rready) begin
                rvalid_d = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            aw_full_q  <= 1'b0;
            w_full_q   <= 1'b0;
            aw_err_q   <= 1'b0;
            ar_err_q   <= 1'b0;
            awaddr_q   <= '0;
            araddr_q   <= '0;
            mem_addr_q <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rdata_q    <= '0;
            bvalid_q   <= 1'b0;
            rvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            rresp_q    <= 2'b00;
        end else begin
            state_q    <= state_d;
            aw_full_q  <= aw_full_d;
            w_full_q   <= w_full_d;
            aw_err_q   <= aw_err_d;
            ar_err_q   <= ar_err_d;
            awaddr_q   <= awaddr_d;
            araddr_q   <= araddr_d;
            mem_addr_q <= mem_addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            rdata_q    <= rdata_d;
            bvalid_q   <= bvalid_d;
            rvalid_q   <= rvalid_d;
            bresp_q    <= bresp_d;
            rresp_q    <= rresp_d;
        end
    end
endmodule

// File: doc/axi4lite_dmem_slave.md
Name: axi4lite_dmem_slave

Overview:
- AXI4-Lite slave front end placed directly upstream of the on-chip data memory (data_mem, 12-bit byte address, byte enables, 1-cycle synchronous read).
- Converts AXI4-Lite write and read transactions from the SoC interconnect into single-cycle data-memory write pulses and registered read accesses.
- Holds the response stable until the master accepts it.
- Handles one outstanding transaction at a time. Writes have priority over reads.

Parameters:
- BASE_ADDR, 32'h0000_1000: base of the 4 KB data-memory window; must be 4 KB aligned.
- MEM_AW, 12: byte-address width presented to the data memory.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- s_axi_awaddr  in  32  write address
- s_axi_awvalid  in  1  write address valid
- s_axi_awready  out  1  write address ready
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  write byte strobes
- s_axi_wvalid  in  1  write data valid
- s_axi_wready  out  1  write data ready
- s_axi_bresp  out  2  write response
- s_axi_bvalid  out  1  write response valid
- s_axi_bready  in  1  write response ready
- s_axi_araddr  in  32  read address
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address ready
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  read response
- s_axi_rvalid  out  1  read data valid
- s_axi_rready  in  1  read data ready
- mem_write  out  1  one-cycle write strobe to data memory
- mem_byte_en  out  4  byte enables to data memory
- mem_addr  out  12  word-aligned byte address to data memory
- mem_wdata  out  32  write data to data memory
- mem_rdata  in  32  data memory read port; registered, valid one cycle after mem_addr

Behaviour:
- Reset (rst=0, asynchronous):
  - All AXI ready/valid outputs, mem_write, mem_byte_en, bresp, rresp and rdata go to 0.
  - State goes to IDLE and the aw_full/w_full holding flags clear.
  - A transaction in flight is dropped. No memory write occurs unless mem_write was already pulsed.
- States: IDLE, WR_RESP, RD_ADDR, RD_CAP, RD_RESP.
- Write channel capture (only in IDLE):
  - s_axi_awready = IDLE & ~aw_full.
  - s_axi_wready = IDLE & ~w_full.
  - AW and W handshakes are independent, in either order or the same cycle. Each latches into its own holding register and sets its flag.
- Write commit:
  - In IDLE with aw_full & w_full, mem_write=1 for exactly that cycle.
  - mem_addr={awaddr_q[11:2],2'b00}, mem_byte_en=wstrb_q, mem_wdata=wdata_q.
  - Flags clear and state moves to WR_RESP with bvalid=1, bresp=2'b00.
  - Latency: both handshakes complete in cycle N, mem_write in N+1, bvalid from N+2.
- WR_RESP: bvalid held until bready. On handshake, bvalid=0 and state returns to IDLE.
- wstrb=4'b0000: mem_write still pulses with mem_byte_en=0 (no bytes change) and an OKAY response.
- Read accept:
  - s_axi_arready = IDLE & ~aw_full & ~w_full & ~s_axi_awvalid & ~s_axi_wvalid (write priority).
  - AR handshake in cycle N latches araddr and moves to RD_ADDR.
- Read sequence:
  - RD_ADDR (N+1): mem_addr={araddr_q[11:2],2'b00}.
  - RD_CAP (N+2): rdata <= mem_rdata, rvalid <= 1, rresp <= 2'b00.
  - RD_RESP from N+3: rdata/rvalid held until rready, then rvalid=0 and state returns to IDLE.
- mem_addr is held at the last latched value outside active cycles. mem_write=0 in every state except commit.
- Simultaneous AW/W/AR valid in IDLE: write path wins; AR waits until the write response completes.
- Address bits [1:0] are ignored. Bits [31:12] are ignored unless the optional feature is enabled.

Optional Feature:
- Macro DMEM_RANGE_CHECK_EN.
- Defined:
  - Writes: if awaddr[31:12] != BASE_ADDR[31:12], the commit cycle keeps mem_write=0 and bresp=2'b10 (SLVERR). Timing is unchanged.
  - Reads: a mismatched read returns rdata=32'h0 and rresp=2'b10 with unchanged latency.
- Undefined: no comparison; responses are always OKAY.

Test Plan:
- AW and W same cycle, awaddr=0x1010, wdata=0xDEADBEEF, wstrb=4'hF -> mem_write pulses next cycle with mem_addr=0x010; bvalid=1, bresp=0 two cycles after handshake.
- W one cycle before AW, wstrb=4'b0010, wdata=0x0000AB00 -> single mem_write, mem_byte_en=4'b0010; a later read of 0x1010 returns 0xDEADABEF.
- Read 0x1010 with rready low for 5 cycles -> rvalid first high 3 cycles after AR handshake; rdata stable at 0xDEADABEF until rready, then rvalid drops.
- AW, W and AR all valid in IDLE -> arready stays 0 until bvalid/bready completes; the read then returns the newly written data.
- rst driven low during WR_RESP and during RD_CAP -> bvalid/rvalid 0 immediately (asynchronous); no extra mem_write; clean IDLE after release.
- With DMEM_RANGE_CHECK_EN, write to 0x2000 -> mem_write stays 0, bresp=2'b10; read of 0x2000 -> rresp=2'b10, rdata=0.
